shift_share_sched: RTL and testbench
====================================

// Module: shift_share_sched
// PURPOSE
//  Scheduler sharing one 26-bit right barrel shifter (stages 8/4/2/1, amounts 0..15) between two requesters: 0 = alignment, 1 = normalisation.
//  Arbitrates round-robin and sequences multi-pass shifts: FP32 amounts 16..25 take two passes; FP16 takes one pass per packed lane.
//  Drives the shifter's fmt/S/X inputs and returns the assembled result over a valid/ready output.
// PARAMETERS
//  W      26  datapath width; FP16 lanes are W/2 = 13 bits
//  SW     8   per-lane shift-amount width
//  SHMAX  15  largest amount the shifter applies in one pass
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  req_valid  in   2      request valid, one bit per requester
//  req_ready  out  2      request accepted when valid & ready
//  req_fmt    in   2      per requester: 0 = FP32, 1 = FP16 (2 packed lanes)
//  req_x0     in   W      requester 0 operand; FP16: lane0 [12:0], lane1 [25:13]
//  req_sa0    in   2*SW   requester 0 amount: [7:0] = FP32 / lane0, [15:8] = lane1
//  req_x1     in   W      requester 1 operand (same layout)
//  req_sa1    in   2*SW   requester 1 amount (same layout)
//  sh_fmt     out  1      to shifter fmt
//  sh_s       out  SW     to shifter S
//  sh_x       out  W      to shifter X
//  sh_r       in   W      shifter result, combinational from sh_s/sh_x
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accept
//  out_r      out  W      shifted result
//  out_id     out  1      requester that owns out_r
//  out_fmt    out  1      format of out_r
// BEHAVIOUR
//  Reset (async, rst_n=0): state = IDLE; out_valid, out_r, out_id, out_fmt = 0; sh_* = 0; req_ready = 0; last_grant = 1, so req 0 wins first.
//  FSM states: IDLE, P0, P1, DONE. sh_x = 0 and sh_s = 0 in IDLE and DONE.
//  IDLE: grant = the only valid requester. If both are valid, grant = !last_grant.
//    req_ready = onehot(grant) only in IDLE with some valid; otherwise 0.
//    On accept, latch x, sa, fmt, id, and set last_grant = id.
//    Then FP32 with sa >= 26 -> out_r = 0, go to DONE; FP32 with sa <= 25 -> P0; FP16 -> P0.
//  P0: FP32 -> sh_x = x, sh_s = min(sa, 15); capture out_r = sh_r.
//      FP32: next P1 if sa > 15, else DONE.
//      FP16 -> sh_x = {13'b0, lane0}, sh_s = sa[7:0]; capture out_r[12:0] = sa[7:0] >= 13 ? 0 : sh_r[12:0]; next P1.
//  P1: FP32 -> sh_x = out_r, sh_s = sa - 15; capture out_r = sh_r; next DONE.
//      FP16 -> sh_x = {13'b0, lane1}, sh_s = sa[15:8]; capture out_r[25:13] = sa[15:8] >= 13 ? 0 : sh_r[12:0]; next DONE.
//  sh_fmt = latched fmt during P0/P1. sh_s[7:4] is always 0 when driven (amounts clamped to <= 15).
//  DONE: out_valid = 1. out_r, out_id, out_fmt are held stable until out_valid & out_ready, then go to IDLE.
//    req_ready = 0 throughout DONE (no accept while a result is pending).
//  Latency, counted from the accept cycle to the first out_valid cycle:
//    FP32 sa >= 26 -> 1; FP32 sa <= 15 -> 2; FP32 sa 16..25 -> 3; FP16 -> 3.
//  Requester inputs are sampled only in the accept cycle; later changes have no effect.
//  req_valid deasserted before ready is not an error: nothing is latched.
//  Reset mid-operation: the in-flight op is dropped, out_valid falls asynchronously, no partial result is emitted.
// TESTING
//  T1 FP32 req0 x=26'h3FFFFFF, sa=4 -> out_r=26'h03FFFFF, id=0, out_valid 2 cycles after accept, sh_s=4 in P0.
//  T2 FP32 req1 x=26'h2000000, sa=20 -> sh_s=15 then 5; out_r=26'h0000020, id=1, latency 3.
//  T3 FP32 sa=30 -> out_r=0, latency 1, shifter never driven (sh_x stays 0).
//  T4 FP16 x={13'h1000,13'h1FFF}, sa={8'd3,8'd14} -> out_r=26'h0400000 (lane1=13'h0200, lane0=0), out_fmt=1, latency 3.
//  T5 both requesters valid for 4 back-to-back ops -> grants 0,1,0,1.
//     Hold out_ready=0 for 5 cycles: out_valid and out_r stable, req_ready=0.
//  T6 rst_n low during P1 of an FP16 op -> out_valid=0 immediately; after release, with both valid, req0 granted first.

Source files
------------

// File: rtl/shift_share_sched.sv
// -----------------------------------------------------------------------------
// shift_share_sched
//
// Shares one W-bit right barrel shifter (single-pass amounts 0..SHMAX) between
// two requesters: 0 = alignment, 1 = normalisation. Requests are arbitrated
// round-robin. Each accepted operation is run as one or two shifter passes:
//   FP32 amount <= 15     : one pass
//   FP32 amount 16..W-1   : two passes (15, then the remainder)
//   FP32 amount >= W      : no pass, the result is zero
//   FP16 (2 packed lanes) : one pass per lane, low lane first
// The assembled result is returned on a valid/ready output port.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (bit i = requester i)
//   req_fmt               per-requester format, 0 = FP32, 1 = FP16 pair
//   req_x0/req_sa0        requester 0 operand and amount(s)
//   req_x1/req_sa1        requester 1 operand and amount(s)
//                         operand FP16: lane0 [HW-1:0], lane1 [W-1:HW]
//                         amount: [SW-1:0] FP32 / lane0, [2*SW-1:SW] lane1
//   sh_fmt/sh_s/sh_x      drive the external shifter
//   sh_r                  shifter result (combinational from sh_s/sh_x)
//   out_valid/out_ready   result handshake
//   out_r/out_id/out_fmt  result, owning requester, result format
// -----------------------------------------------------------------------------
module shift_share_sched #(
    parameter int W     = 26,
    parameter int SW    = 8,
    parameter int SHMAX = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [1:0]      req_fmt,
    input  logic [W-1:0]    req_x0,
    input  logic [2*SW-1:0] req_sa0,
    input  logic [W-1:0]    req_x1,
    input  logic [2*SW-1:0] req_sa1,
    output logic            sh_fmt,
    output logic [SW-1:0]   sh_s,
    output logic [W-1:0]    sh_x,
    input  logic [W-1:0]    sh_r,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W-1:0]    out_r,
    output logic            out_id,
    output logic            out_fmt
);

    // FP16 lane widths: lane0 is the low half, lane1 takes the remainder.
    localparam int HW = W / 2;
    localparam int HI = W - HW;

    // Amount thresholds as SW-bit constants so comparisons stay width-matched.
    localparam logic [SW-1:0] SA_LANE = SW'(HW);     // lane fully shifted out
    localparam logic [SW-1:0] SA_MAX  = SW'(SHMAX);  // single-pass limit
    localparam logic [SW-1:0] SA_ZERO = SW'(W);      // FP32 fully shifted out

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_P0   = 2'd1;
    localparam logic [1:0] S_P1   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]      state;
    logic            last_grant;
    logic [W-1:0]    x_q;
    logic [2*SW-1:0] sa_q;
    logic            fmt_q;

    logic            grant;
    logic            accept;
    logic [W-1:0]    sel_x;
    logic [2*SW-1:0] sel_sa;
    logic            sel_fmt;
    logic [SW-1:0]   sa_lo;
    logic [SW-1:0]   sa_hi;

    function automatic logic [SW-1:0] clamp_sa(input logic [SW-1:0] a);
        return (a > SA_MAX) ? SA_MAX : a;
    endfunction

    // ---------------------------------------------------------------- arbiter
    // A lone requester always wins; when both ask, the one not served last
    // time wins.
    always_comb begin
        // NOTE: every combinationally assigned signal gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        grant = 1'b0;
        if (req_valid == 2'b11) begin
            grant = ~last_grant;
        end else if (req_valid[1]) begin
            grant = 1'b1;
        end
    end

    assign req_ready = (state == S_IDLE && |req_valid) ? (grant ? 2'b10 : 2'b01)
                                                        : 2'b00;
    assign accept    = |(req_valid & req_ready);

    assign sel_x   = grant ? req_x1  : req_x0;
    assign sel_sa  = grant ? req_sa1 : req_sa0;
    assign sel_fmt = req_fmt[grant];

    assign sa_lo = sa_q[SW-1:0];
    assign sa_hi = sa_q[2*SW-1:SW];

    // ---------------------------------------------------------- shifter drive
    // The shifter is idle (all zero) outside P0/P1. The second FP32 pass
    // re-shifts the partial result already captured in out_r.
    always_comb begin
        sh_fmt = 1'b0;
        sh_s   = '0;
        sh_x   = '0;
        case (state)
            S_P0: begin
                sh_fmt = fmt_q;
                sh_s   = clamp_sa(sa_lo);
                sh_x   = fmt_q ? {{HI{1'b0}}, x_q[HW-1:0]} : x_q;
            end
            S_P1: begin
                sh_fmt = fmt_q;
                if (fmt_q) begin
                    sh_s = clamp_sa(sa_hi);
                    sh_x = {{HW{1'b0}}, x_q[W-1:HW]};
                end else begin
                    sh_s = sa_lo - SA_MAX;
                    sh_x = out_r;
                end
            end
            default: ;
        endcase
    end

    assign out_valid = (state == S_DONE);

    // --------------------------------------------------------------- sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= 1'b1;
            x_q        <= '0;
            sa_q       <= '0;
            fmt_q      <= 1'b0;
            out_r      <= '0;
            out_id     <= 1'b0;
            out_fmt    <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        x_q        <= sel_x;
                        sa_q       <= sel_sa;
                        fmt_q      <= sel_fmt;
                        out_id     <= grant;
                        out_fmt    <= sel_fmt;
                        last_grant <= grant;
                        if (!sel_fmt && sel_sa[SW-1:0] >= SA_ZERO) begin
                            out_r <= '0;
                            state <= S_DONE;
                        end else begin
                            state <= S_P0;
                        end
                    end
                end
                S_P0: begin
                    if (fmt_q) begin
                        out_r[HW-1:0] <= (sa_lo >= SA_LANE) ? '0 : sh_r[HW-1:0];
                        state         <= S_P1;
                    end else begin
                        out_r <= sh_r;
                        state <= (sa_lo > SA_MAX) ? S_P1 : S_DONE;
                    end
                end
                S_P1: begin
                    if (fmt_q) begin
                        out_r[W-1:HW] <= (sa_hi >= SA_LANE) ? '0 : sh_r[HI-1:0];
                    end else begin
                        out_r <= sh_r;
                    end
                    state <= S_DONE;
                end
                default: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_share_sched.sv
// -----------------------------------------------------------------------------
// tb_shift_share_sched
//
// Bench for shift_share_sched. Provides a behavioural 26-bit shifter on the
// sh_* port, runs a table of single operations, then hand-written sequences
// for arbitration, output back-pressure and reset in the middle of an op.
// Expected results are queued when a request is accepted and compared when
// the DUT presents its result.
// -----------------------------------------------------------------------------
module tb_shift_share_sched;

    localparam int W  = 26;
    localparam int SW = 8;

    logic            clk;
    logic            rst_n;
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [1:0]      req_fmt;
    logic [W-1:0]    req_x0;
    logic [2*SW-1:0] req_sa0;
    logic [W-1:0]    req_x1;
    logic [2*SW-1:0] req_sa1;
    logic            sh_fmt;
    logic [SW-1:0]   sh_s;
    logic [W-1:0]    sh_x;
    logic [W-1:0]    sh_r;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_r;
    logic            out_id;
    logic            out_fmt;

    shift_share_sched #(.W(W), .SW(SW), .SHMAX(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_fmt   (req_fmt),
        .req_x0    (req_x0),
        .req_sa0   (req_sa0),
        .req_x1    (req_x1),
        .req_sa1   (req_sa1),
        .sh_fmt    (sh_fmt),
        .sh_s      (sh_s),
        .sh_x      (sh_x),
        .sh_r      (sh_r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_id    (out_id),
        .out_fmt   (out_fmt)
    );

    // Behavioural shifter: full-width in FP32, two independent 13-bit lanes
    // in FP16.
    always_comb begin
        if (sh_fmt) sh_r = {sh_x[25:13] >> sh_s, sh_x[12:0] >> sh_s};
        else        sh_r = sh_x >> sh_s;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ bookkeeping
    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic         id;
        logic         fmt;
        logic [W-1:0] r;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        logic         id;
        logic         fmt;
        logic [W-1:0] x;
        logic [15:0]  sa;
        logic [W-1:0] exp_r;
        int           lat;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL %s_sb: result seen with no expected entry queued", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_out_r"},   out_r,   e.r);
        check({tag, "_out_id"},  out_id,  e.id);
        check({tag, "_out_fmt"}, out_fmt, e.fmt);
    endtask

    task automatic wait_any_ready(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (|req_ready) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!ok) check({tag, "_ready_timeout"}, 0, 1);
    endtask

    task automatic wait_out_valid(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (out_valid) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        if (!ok) check({tag, "_valid_timeout"}, 0, 1);
    endtask

    task automatic drive_req(input logic id, input logic fmt, input logic [W-1:0] x,
                             input logic [15:0] sa);
        req_fmt     = 2'b00;
        req_fmt[id] = fmt;
        if (id) begin req_x1 = x; req_sa1 = sa; end
        else    begin req_x0 = x; req_sa0 = sa; end
        req_valid     = 2'b00;
        req_valid[id] = 1'b1;
    endtask

    task automatic scramble_inputs();
        req_x0  = W'($urandom);
        req_x1  = W'($urandom);
        req_sa0 = 16'($urandom);
        req_sa1 = 16'($urandom);
        req_fmt = 2'($urandom);
    endtask

    // Expected shifter amount for pass p of an operation.
    function automatic logic [7:0] exp_pass(input logic fmt, input logic [15:0] sa, input int p);
        if (fmt) return (p == 0) ? sa[7:0] : sa[15:8];
        if (p == 0) return (sa[7:0] > 8'd15) ? 8'd15 : sa[7:0];
        return sa[7:0] - 8'd15;
    endfunction

    // One complete table-driven operation with out_ready held high.
    task automatic run_vec(input int k, input vec_t v);
        string        tag;
        bit           ok;
        int           lat;
        int           npass;
        logic [7:0]   pass_s[2];
        logic [W-1:0] sh_x_or;
        exp_t         e;

        tag = $sformatf("vec%0d", k);
        @(negedge clk);
        out_ready = 1'b1;
        drive_req(v.id, v.fmt, v.x, v.sa);
        #1;
        wait_any_ready(tag, ok);
        if (!ok) return;
        check({tag, "_grant"}, req_ready, v.id ? 2'b10 : 2'b01);
        e.id = v.id; e.fmt = v.fmt; e.r = v.exp_r;
        sb.push_back(e);

        @(posedge clk); #1;
        req_valid = 2'b00;
        scramble_inputs();

        lat = 0; npass = 0; sh_x_or = '0; ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin ok = 1'b1; break; end
            if (npass < 2) pass_s[npass] = sh_s;
            npass++;
            sh_x_or |= sh_x;
            check($sformatf("%s_sh_fmt_p%0d", tag, i), sh_fmt, v.fmt);
        end
        if (!ok) begin
            check({tag, "_valid_timeout"}, 0, 1);
            return;
        end
        check({tag, "_latency"}, lat, v.lat);
        check({tag, "_passes"}, npass, v.lat - 1);
        for (int p = 0; p < 2 && p < npass; p++)
            check($sformatf("%s_sh_s_p%0d", tag, p), pass_s[p], exp_pass(v.fmt, v.sa, p));
        if (v.lat == 1) check({tag, "_sh_x_unused"}, sh_x_or, 0);
        check({tag, "_sh_x_done"}, sh_x, 0);
        pop_compare(tag);
        @(posedge clk); #1;
        check({tag, "_released"}, out_valid, 0);
    endtask

    // ------------------------------------------------------------------ tests
    initial begin
        bit ok;
        exp_t e;
        logic [W-1:0] t5_x[2];
        logic [15:0]  t5_sa[2];
        logic [W-1:0] t5_r[2];

        //          id    fmt   x             sa        exp_r         lat
        vecs[0] = '{1'b0, 1'b0, 26'h3FFFFFF, 16'h0004, 26'h03FFFFF, 2};  // T1
        vecs[1] = '{1'b1, 1'b0, 26'h2000000, 16'h0014, 26'h0000020, 3};  // T2
        vecs[2] = '{1'b0, 1'b0, 26'h1234567, 16'h001E, 26'h0000000, 1};  // T3
        vecs[3] = '{1'b1, 1'b1, {13'h1000, 13'h1FFF}, 16'h030E, 26'h0400000, 3};  // T4
        vecs[4] = '{1'b0, 1'b0, 26'h3FFFFFF, 16'h000F, 26'h00007FF, 2};  // one-pass limit
        vecs[5] = '{1'b1, 1'b0, 26'h3FFFFFF, 16'h0010, 26'h00003FF, 3};  // first two-pass
        vecs[6] = '{1'b0, 1'b0, 26'h3FFFFFF, 16'h0019, 26'h0000001, 3};  // largest nonzero
        vecs[7] = '{1'b1, 1'b0, 26'h3FFFFFF, 16'h001A, 26'h0000000, 1};  // shifted out
        vecs[8] = '{1'b0, 1'b1, 26'h3FFFFFF, 16'h0D0C, 26'h0000001, 3};  // lane limits
        vecs[9] = '{1'b1, 1'b0, 26'h1555555, 16'h0000, 26'h1555555, 2};  // zero amount

        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_fmt   = 2'b00;
        req_x0    = '0;
        req_x1    = '0;
        req_sa0   = '0;
        req_sa1   = '0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_out_r",     out_r,     0);
        check("rst_out_id",    out_id,    0);
        check("rst_out_fmt",   out_fmt,   0);
        check("rst_sh_x",      sh_x,      0);
        check("rst_sh_s",      sh_s,      0);
        check("rst_sh_fmt",    sh_fmt,    0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single operations
        foreach (vecs[k]) run_vec(k, vecs[k]);

        // T5: both requesters valid, four back-to-back ops, back-pressure on #2
        t5_x[0] = 26'h0F0F0F0; t5_sa[0] = 16'h0004; t5_r[0] = 26'h00F0F0F;
        t5_x[1] = 26'h3000000; t5_sa[1] = 16'h0008; t5_r[1] = 26'h0030000;
        @(negedge clk);
        out_ready = 1'b1;
        req_fmt   = 2'b00;
        req_x0 = t5_x[0]; req_sa0 = t5_sa[0];
        req_x1 = t5_x[1]; req_sa1 = t5_sa[1];
        req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            wait_any_ready("t5", ok);
            if (!ok) break;
            check($sformatf("t5_grant%0d", k), req_ready, (k % 2) ? 2'b10 : 2'b01);
            e.id = 1'(k % 2); e.fmt = 1'b0; e.r = t5_r[k % 2];
            sb.push_back(e);
            @(posedge clk); #1;
            if (k == 1) out_ready = 1'b0;
            wait_out_valid("t5", ok);
            if (!ok) break;
            if (k == 1) begin
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk); #1;
                    check($sformatf("t5_hold_valid%0d", c), out_valid, 1);
                    check($sformatf("t5_hold_r%0d", c),     out_r,     t5_r[1]);
                    check($sformatf("t5_hold_ready%0d", c), req_ready, 0);
                end
                out_ready = 1'b1;
            end
            pop_compare($sformatf("t5_op%0d", k));
            @(posedge clk); #1;
        end
        req_valid = 2'b00;

        // Reset while a result is pending: out_valid must drop without a clock
        @(negedge clk);
        out_ready = 1'b0;
        drive_req(1'b1, 1'b0, 26'h2AAAAAA, 16'h001E);
        #1;
        wait_any_ready("rstdone", ok);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_out_valid("rstdone", ok);
        check("rstdone_pending", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstdone_valid_async", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // T6: reset during P1 of an FP16 op from requester 0
        @(negedge clk);
        out_ready = 1'b1;
        drive_req(1'b0, 1'b1, {13'h1ABC, 13'h0F0F}, 16'h0203);
        #1;
        wait_any_ready("t6", ok);
        @(posedge clk); #1;          // now in P0
        req_valid = 2'b00;
        @(posedge clk); #1;          // now in P1
        check("t6_in_p1_sh_x", sh_x, {13'h0, 13'h1ABC});
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid",  out_valid, 0);
        check("t6_rst_sh_x",   sh_x,      0);
        check("t6_rst_out_r",  out_r,     0);
        check("t6_rst_ready",  req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check($sformatf("t6_no_partial%0d", c), out_valid, 0);
        end
        // Requester 0 was served last, yet reset restores its priority.
        req_fmt = 2'b00;
        req_x0 = 26'h0000F00; req_sa0 = 16'h0008;
        req_x1 = 26'h3FFFFFF; req_sa1 = 16'h0001;
        req_valid = 2'b11;
        #1;
        wait_any_ready("t6_after", ok);
        check("t6_first_grant", req_ready, 2'b01);
        e.id = 1'b0; e.fmt = 1'b0; e.r = 26'h000000F;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 2'b00;
        wait_out_valid("t6_after", ok);
        if (ok) pop_compare("t6_after");
        @(posedge clk); #1;

        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
